rnd_hex_source: RTL and testbench
=================================

// Module: rnd_hex_source
// PURPOSE
//  Produces the 16-bit value that hex_display shows, from one push-button.
//  A free-running 16-bit Galois LFSR supplies pseudo-random values.
//  While the button is held, the output "rolls" through LFSR values; on release it freezes on a final value.
//  Sits between the board button pin and hex_display.i_data.
// PARAMETERS
//  SEED        16'hACE1  LFSR reset value; a value of 0 is replaced by 16'hACE1
//  DEB_WIDTH   16        debounce counter width; a level must be stable 2**DEB_WIDTH clks to be accepted
//  ROLL_WIDTH  22        roll divider width; while rolling, o_data updates every 2**ROLL_WIDTH clks
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   reset, asynchronous, active-low
//  i_btn      in   1   raw button, active-high, asynchronous to clk, bouncing
//  o_data     out  16  value for the display
//  o_valid    out  1   1-clk pulse when a final value is latched on release
//  o_rolling  out  1   high while in ROLL
// BEHAVIOUR
//  Reset values (all flops async-cleared by rst_n):
//   - lfsr = SEED; o_data = 16'h0000; o_valid = 0; o_rolling = 0
//   - state = IDLE; sync/debounce flops = 0; roll counter = 0
//  Synchroniser and debounce:
//   - i_btn passes through 2 flip-flops.
//   - The debounce counter clears whenever the synced level equals the stable level; otherwise it increments.
//   - When the counter reaches all-ones while the two levels still differ, the stable level flips and the counter clears.
//   - The synced level must therefore differ from the stable level for 2**DEB_WIDTH consecutive clks before the stable level flips.
//   - A single differing clk restarts the count.
//   - press = 1-clk rise of the stable level; release = 1-clk fall of the stable level.
//  LFSR:
//   - Steps every clk, including in IDLE, so press timing adds entropy.
//   - next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0)
//   - Period 65535; the value 0 is never reached.
//  FSM (2 states):
//   - IDLE: o_data holds. On press -> ROLL: o_data <= lfsr, roll counter <= 0.
//   - ROLL: roll counter increments each clk. When it wraps from all-ones to 0, o_data <= lfsr.
//     On release -> IDLE: o_data <= lfsr, o_valid = 1 for exactly that one clk.
//  Timing and boundary rules:
//   - o_rolling = (state == ROLL), registered, same cycle as the state change.
//   - Release has priority over a roll wrap in the same clk: a single load, and o_valid pulses.
//   - Latency: the o_data update and o_valid are visible 1 clk after the debounced edge.
//   - Press-to-first-update = 2 sync + 2**DEB_WIDTH debounce + 1 clk.
//   - A button shorter than 2**DEB_WIDTH clks is ignored: no state change, no o_valid.
//   - Reset mid-ROLL returns to IDLE with o_data = 0 and no o_valid pulse.
//  Widths: all counters are unsigned and wrap modulo 2**width; no saturation.
// STRUCTURE
//  Shared header rnd_hex_defs.vh holds:
//   - LFSR_TAPS = 16'hB400
//   - DEFAULT_SEED = 16'hACE1
//   - state encodings ST_IDLE = 1'b0, ST_ROLL = 1'b1
//  Sub-module btn_debounce #(DEB_WIDTH) (clk, rst_n, i_raw, o_level, o_rise, o_fall) contains the synchroniser and debouncer.
//  The LFSR, FSM and roll divider stay in this module.
// TESTING (sim with DEB_WIDTH=3, ROLL_WIDTH=4)
//  1. Reset, then release rst_n:
//     - o_data = 0, o_valid = 0, o_rolling = 0
//     - lfsr reads 16'hACE1, then 16'hE270 on the next clk
//  2. Glitchy press, i_btn high for 5 clks then low:
//     - o_rolling stays 0; o_data unchanged; no o_valid
//  3. Clean press held 100 clks:
//     - o_rolling rises 11 clks after i_btn rises (2 sync + 8 debounce + 1)
//     - o_data changes at entry, then every 16 clks, each time equal to the model LFSR value
//  4. Release:
//     - exactly one o_valid pulse; o_data equals the model LFSR value at that clk
//     - o_data then stable for 200 clks
//  5. Release timed onto a roll-wrap clk:
//     - a single o_data load and one o_valid pulse
//  6. rst_n asserted mid-ROLL:
//     - o_data = 0 and o_rolling = 0 immediately (async); no o_valid pulse
//  Also: SEED = 0 -> LFSR starts at 16'hACE1; a 65535-step run never hits 0 and returns to the seed.

Source files
------------

// File: rtl/rnd_hex_source_pkg.sv
// Shared constants, state type and LFSR step function for the random hex source.
package rnd_hex_source_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROLL = 1'b1
  } state_t;

  // One right-shift Galois step; a non-zero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for a bouncing push-button.
// Produces the accepted level and one-clock rise/fall pulses aligned with it.
module btn_debounce #(
  parameter int DEB_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                 sync1;
  logic                 sync2;
  logic [DEB_WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
    end
  end

  // Any clock where the synced level agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (sync2 == o_level) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt     <= '0;
        o_level <= sync2;
        o_rise  <= sync2;
        o_fall  <= ~sync2;
      end else begin
        cnt <= cnt + DEB_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/rnd_hex_source.sv
// Button-driven random value source: rolls through LFSR values while the button
// is held and freezes on a final value, pulsing o_valid, when it is released.
module rnd_hex_source
  import rnd_hex_source_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          DEB_WIDTH  = 16,
  parameter int          ROLL_WIDTH = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_btn,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_rolling
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic                  btn_level;
  logic                  btn_rise;
  logic                  btn_fall;
  logic                  press;
  logic [15:0]           lfsr;
  state_t                state;
  state_t                state_nxt;
  logic [ROLL_WIDTH-1:0] roll_cnt;
  logic [ROLL_WIDTH-1:0] roll_nxt;
  logic [15:0]           data_nxt;
  logic                  valid_nxt;

  btn_debounce #(
    .DEB_WIDTH(DEB_WIDTH)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (i_btn),
    .o_level(btn_level),
    .o_rise (btn_rise),
    .o_fall (btn_fall)
  );

  assign press = btn_rise & btn_level;

  // Free-running in every state so the moment of the press picks the sequence point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    roll_nxt  = roll_cnt;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press) begin
          state_nxt = ST_ROLL;
          roll_nxt  = '0;
          data_nxt  = lfsr;
        end
      end
      ST_ROLL: begin
        roll_nxt = roll_cnt + ROLL_WIDTH'(1);
        // Release wins over a coincident roll wrap: one load, and the final value is flagged.
        if (btn_fall) begin
          state_nxt = ST_IDLE;
          data_nxt  = lfsr;
          valid_nxt = 1'b1;
        end else if (&roll_cnt) begin
          data_nxt = lfsr;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      roll_cnt  <= '0;
      o_data    <= 16'h0000;
      o_valid   <= 1'b0;
      o_rolling <= 1'b0;
    end else begin
      state     <= state_nxt;
      roll_cnt  <= roll_nxt;
      o_data    <= data_nxt;
      o_valid   <= valid_nxt;
      o_rolling <= (state_nxt == ST_ROLL);
    end
  end

endmodule

// File: tb/tb_rnd_hex_source.sv
// Scoreboard bench for rnd_hex_source: stimulus predicts output events from a
// reference LFSR table, a negedge monitor pops and compares them.
module tb_rnd_hex_source;

  localparam int DW   = 3;
  localparam int RW   = 4;
  localparam int LMAX = 8192;
  localparam int LAT  = 2 + (1 << DW) + 1;
  localparam int ROLL = 1 << RW;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        valid;
    logic        rolling;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_btn = 1'b0;
  wire  [15:0] o_data;
  wire         o_valid;
  wire         o_rolling;

  logic        rst0_n = 1'b0;
  logic        btn0 = 1'b0;
  wire  [15:0] data0;
  wire         valid0;
  wire         rolling0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] lref [0:LMAX-1];
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_data;
  logic        prev_rolling;
  logic        lfsr_done = 1'b0;

  rnd_hex_source #(.SEED(16'hACE1), .DEB_WIDTH(DW), .ROLL_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn),
    .o_data(o_data), .o_valid(o_valid), .o_rolling(o_rolling)
  );

  rnd_hex_source #(.SEED(16'h0000), .DEB_WIDTH(DW), .ROLL_WIDTH(RW)) dut0 (
    .clk(clk), .rst_n(rst0_n), .i_btn(btn0),
    .o_data(data0), .o_valid(valid0), .o_rolling(rolling0)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Any data/rolling change or a high o_valid is an output event to be matched.
  always @(negedge clk) begin
    if (rst_n && (o_data !== prev_data || o_rolling !== prev_rolling || o_valid !== 1'b0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: cyc=%0d data=0x%0h valid=%b rolling=%b, no event expected",
                 cyc, o_data, o_valid, o_rolling);
      end else begin
        mon_e = sb.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_data", o_data, mon_e.data);
        check("event_valid", o_valid, mon_e.valid);
        check("event_rolling", o_rolling, mon_e.rolling);
      end
    end
    prev_data    = o_data;
    prev_rolling = o_rolling;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic v, input logic r);
    exp_t e;
    e.cyc = c; e.data = lref[c-1]; e.valid = v; e.rolling = r;
    sb.push_back(e);
  endtask

  // Button held for 'hold' clocks; returns the value expected to be frozen.
  task automatic press_release(input int hold, output logic [15:0] final_val);
    int p0, e, f;
    p0 = cyc;
    e  = p0 + LAT;
    f  = p0 + hold + LAT;
    push(e, 1'b0, 1'b1);
    for (int t = e + ROLL; t < f; t += ROLL) push(t, 1'b0, 1'b1);
    push(f, 1'b1, 1'b0);
    final_val = lref[f-1];
    i_btn = 1'b1;
    tick(hold);
    i_btn = 1'b0;
    tick(40);
  endtask

  task automatic glitch(input int len);
    logic [15:0] d0;
    d0 = o_data;
    i_btn = 1'b1;
    tick(len);
    i_btn = 1'b0;
    tick(20);
    check("glitch_rolling", o_rolling, 1'b0);
    check("glitch_data", o_data, d0);
  endtask

  initial begin : seed_zero_run
    int zero_hits;
    zero_hits = 0;
    #23 rst0_n = 1'b1;
    #1 check("seed0_reset_lfsr", dut0.lfsr, 16'hACE1);
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      if (dut0.lfsr == 16'h0000) zero_hits++;
      if (i == 1) check("seed0_first_step", dut0.lfsr, 16'hE270);
    end
    check("seed0_never_zero", zero_hits, 0);
    check("seed0_period", dut0.lfsr, 16'hACE1);
    check("seed0_idle_data", data0, 16'h0000);
    check("seed0_idle_flags", {valid0, rolling0}, 2'b00);
    lfsr_done = 1'b1;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] fv;
    int          hold;
    lref[0] = 16'hACE1;
    for (int i = 1; i < LMAX; i++) lref[i] = model_next(lref[i-1]);

    // Reset state and first LFSR step.
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("reset_data", o_data, 16'h0000);
    check("reset_flags", {o_valid, o_rolling}, 2'b00);
    check("reset_lfsr", dut.lfsr, 16'hACE1);
    tick(1);
    check("lfsr_step1", dut.lfsr, 16'hE270);
    check("lfsr_model", dut.lfsr, lref[cyc]);

    // Short and bouncy presses must be ignored.
    glitch(5);
    glitch((1 << DW) - 1);
    for (int i = 0; i < 12; i++) begin
      i_btn = (i % 5 == 4) ? 1'b0 : 1'($urandom_range(1, 0));
      tick(1);
    end
    i_btn = 1'b0;
    tick(20);
    check("bounce_rolling", o_rolling, 1'b0);
    check("bounce_idle_queue", sb.size(), 0);

    // Shortest accepted press, a long roll, and releases onto a roll wrap.
    press_release(1 << DW, fv);
    press_release(100, fv);
    tick(200);
    check("frozen_after_release", o_data, fv);
    press_release(3 * ROLL, fv);
    press_release(4 * ROLL - 1, fv);
    for (int i = 0; i < 6; i++) begin
      hold = int'($urandom_range(90, 1 << DW));
      press_release(hold, fv);
    end
    check("queue_drained", sb.size(), 0);

    // Asynchronous reset in the middle of a roll.
    begin : reset_mid_roll
      int p0, e;
      p0 = cyc;
      e  = p0 + LAT;
      push(e, 1'b0, 1'b1);
      push(e + ROLL, 1'b0, 1'b1);
      push(e + 2 * ROLL, 1'b0, 1'b1);
      i_btn = 1'b1;
      tick(LAT + 2 * ROLL + 5);
      #2 rst_n = 1'b0;
      #1;
      check("midroll_reset_data", o_data, 16'h0000);
      check("midroll_reset_flags", {o_valid, o_rolling}, 2'b00);
      check("midroll_reset_lfsr", dut.lfsr, 16'hACE1);
      check("midroll_events_seen", sb.size(), 0);
      i_btn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick(30);
      check("post_reset_data", o_data, 16'h0000);
      check("post_reset_flags", {o_valid, o_rolling}, 2'b00);
    end

    press_release(30, fv);
    check("final_queue_empty", sb.size(), 0);

    wait (lfsr_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
